bitrev_streamer: RTL and testbench
==================================

# bitrev_streamer

Buffers one 32-point frame of complex samples written in natural index order, then streams it out serially in bit-reversed index order. It is the producer side of the sorter's serial interface: `start_sorting`, `out_r` and `out_i` connect directly to the sorter's inputs of the same names. It supplies stimulus for sorter verification, and feeds the FFT datapath wherever a bit-reversed serial stream is required.

## Interface
- `DATA_W`, 16: width of each real/imaginary sample, signed two's complement.
- `LOG2N`, 5: log2 of frame length; N = 32.

- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: an input sample is present.
- `in_ready` output 1: the block can accept a sample this cycle.
- `in_r` input DATA_W: real part of the input sample, signed.
- `in_i` input DATA_W: imaginary part of the input sample, signed.
- `start_sorting` output 1: one-cycle pulse, coincident with output sample 0 of each frame.
- `out_valid` output 1: `out_r`/`out_i` carry a valid sample.
- `out_r` output DATA_W: real part of the output sample, registered.
- `out_i` output DATA_W: imaginary part of the output sample, registered.

## Operation
- Storage: N×(2·DATA_W) buffer, with a write counter `wr_cnt` and a read counter `rd_cnt`, each LOG2N bits.
- States:
  - IDLE: entered on reset. Moves to FILL on the first clock edge after `rst` deasserts.
  - FILL: `in_ready`=1. When `in_valid && in_ready`, the sample is written to address `wr_cnt` and `wr_cnt` increments. On the accept with `wr_cnt`=N-1, `wr_cnt` wraps to 0 and the state moves to DRAIN.
  - DRAIN: one sample is output every cycle, with no output backpressure.
    - Output k (k=0..N-1) is `buf[bitrev(k)]`, where `bitrev` mirrors the LOG2N index bits. Example: 1→16, 3→24, 6→12.
    - `start_sorting`=1 only for k=0.
    - After k=N-1, `rd_cnt` wraps to 0 and the state returns to FILL.
- Samples are stored unmodified; no arithmetic on data.
- `in_valid` may drop at any time during FILL. Gaps are allowed and the frame completes when the 32nd sample is accepted.
- `in_valid` while `in_ready`=0 is ignored; the sample is not written.
- Reset mid-operation: a partial fill or drain is discarded, counters are cleared, and no further output occurs.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `start_sorting`=0, `out_r`=0, `out_i`=0, both counters 0.
- `in_ready` is 0 in the cycle after reset release and 1 from the following cycle.
- Latency: when the last sample is accepted at edge E, output sample 0 with `start_sorting`=1 appears after edge E+1.
- Each frame is exactly 32 consecutive `out_valid` cycles.
- `start_sorting` and `out_valid` are registered. Between frames, `out_r`/`out_i` hold their last value and `out_valid`=0.
- Without ping-pong: `in_ready`=0 throughout DRAIN and returns to 1 in the cycle after output k=31. The minimum frame period is 64 cycles plus the transfer overhead.

## Configuration
- Macro: `BITREV_PINGPONG_EN`.
- Defined:
  - Two N-entry banks are used. The write bank and read bank swap when a fill completes and the read bank is idle.
  - `in_ready` stays 1 during DRAIN, so fill and drain run concurrently.
  - If a fill completes on the same edge as output k=31, the next frame's sample 0 with `start_sorting` follows with no idle cycle.
  - If the fill completes while a drain is in progress, `in_ready` drops until the swap occurs.
- Undefined: a single bank is used, with the FILL/DRAIN exclusion described above.

## Test plan
- Ramp frame: input `in_r`=k, `in_i`=-k for k=0..31 with `in_valid` held high. Required output `out_r` sequence: 0,16,8,24,4,20,12,28,2,18,…,31. `out_i` is the negation of `out_r` at every position. `start_sorting` is high only with sample 0.
- Gapped input: `in_valid` toggles every other cycle. Required: frame accepted after 32 accepts, identical output order, first output one cycle after the last accept.
- Backpressure: drive `in_valid`=1 during DRAIN (single-bank build) with value 0x7FFF. Required: the value is not stored, `in_ready`=0 throughout DRAIN, and the next frame is unaffected.
- Reset mid-drain: pull `rst` low at output k=10. Required: all outputs are 0 immediately, and a new 32-sample frame after release produces correct order from sample 0.
- Extremes: samples 0x8000/0x7FFF alternating. Required: values pass through bit-exact at positions bitrev(k).
- `BITREV_PINGPONG_EN` back-to-back: two frames input continuously. Required: 64 contiguous `out_valid` cycles, `start_sorting` pulses exactly 32 cycles apart, second frame correct.

Source files
------------

// File: rtl/bitrev_streamer.sv
// bitrev_streamer: buffers one N-point frame of complex samples written in
// natural order and streams it out serially in bit-reversed index order.
// Optional feature macro: BITREV_PINGPONG_EN (two banks, fill and drain overlap).
//
// Handshake: an input sample moves on a rising edge where in_valid && in_ready
// are both 1; in_valid while in_ready=0 is ignored. The output side has no
// backpressure: every cycle with out_valid=1 carries one sample.
module bitrev_streamer #(
  parameter int DATA_W = 16,
  parameter int LOG2N  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_r,
  input  logic signed [DATA_W-1:0] in_i,
  output logic                     start_sorting,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_r,
  output logic signed [DATA_W-1:0] out_i
);

  localparam logic [LOG2N-1:0] CNT_LAST = '1;
`ifdef BITREV_PINGPONG_EN
  localparam int AW = LOG2N + 1;
`else
  localparam int AW = LOG2N;
`endif
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t                  state;
  logic [LOG2N-1:0]        wr_cnt;
  logic [LOG2N-1:0]        rd_cnt;
  logic [2*DATA_W-1:0]     mem [DEPTH];
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [AW-1:0]           rd_addr;

  // Mirror the LOG2N index bits (e.g. 1 -> 16, 3 -> 24 for LOG2N=5).
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int b = 0; b < LOG2N; b++) r[LOG2N-1-b] = a[b];
    return r;
  endfunction

  assign wr_en = in_valid && in_ready;

`ifdef BITREV_PINGPONG_EN
  logic wr_bank;
  logic rd_bank;
  logic draining;
  logic full_pending;
  logic fill_done;
  logic last_rd;
  logic swap;

  assign wr_addr   = {wr_bank, wr_cnt};
  assign rd_addr   = {rd_bank, bitrev(rd_cnt)};
  assign fill_done = wr_en && (wr_cnt == CNT_LAST);
  assign last_rd   = draining && (rd_cnt == CNT_LAST);
  // A full bank is handed to the reader once the reader is idle or finishing.
  assign swap      = (state == FILL) && (fill_done || full_pending) &&
                     (!draining || last_rd);
`else
  assign wr_addr = wr_cnt;
  assign rd_addr = bitrev(rd_cnt);
`endif

  // Sample buffer write port; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {in_r, in_i};
  end

  // Control FSM, counters and registered output stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      start_sorting <= 1'b0;
      out_r         <= '0;
      out_i         <= '0;
`ifdef BITREV_PINGPONG_EN
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      draining      <= 1'b0;
      full_pending  <= 1'b0;
`endif
    end else begin
`ifdef BITREV_PINGPONG_EN
      case (state)
        IDLE: begin
          state    <= FILL;
          in_ready <= 1'b1;
        end
        FILL: begin
          if (wr_en) wr_cnt <= wr_cnt + LOG2N'(1);
          if (draining) begin
            out_r         <= mem[rd_addr][2*DATA_W-1:DATA_W];
            out_i         <= mem[rd_addr][DATA_W-1:0];
            out_valid     <= 1'b1;
            start_sorting <= (rd_cnt == '0);
            rd_cnt        <= rd_cnt + LOG2N'(1);
          end else begin
            out_valid     <= 1'b0;
            start_sorting <= 1'b0;
          end
          if (swap) begin
            rd_bank      <= wr_bank;
            wr_bank      <= ~wr_bank;
            draining     <= 1'b1;
            full_pending <= 1'b0;
            in_ready     <= 1'b1;
          end else begin
            if (last_rd) draining <= 1'b0;
            // Both banks busy: hold the writer off until the reader frees one.
            if (fill_done) begin
              full_pending <= 1'b1;
              in_ready     <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
`else
      case (state)
        IDLE: begin
          state    <= FILL;
          in_ready <= 1'b1;
        end
        FILL: begin
          out_valid     <= 1'b0;
          start_sorting <= 1'b0;
          in_ready      <= 1'b1;
          if (wr_en) begin
            wr_cnt <= wr_cnt + LOG2N'(1);
            if (wr_cnt == CNT_LAST) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          out_r         <= mem[rd_addr][2*DATA_W-1:DATA_W];
          out_i         <= mem[rd_addr][DATA_W-1:0];
          out_valid     <= 1'b1;
          start_sorting <= (rd_cnt == '0);
          rd_cnt        <= rd_cnt + LOG2N'(1);
          // in_ready stays low here; FILL raises it one cycle after k=N-1.
          if (rd_cnt == CNT_LAST) state <= FILL;
        end
        default: state <= IDLE;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_bitrev_streamer.sv
// Directed bench for bitrev_streamer: ramp, gapped, backpressure, reset
// mid-drain, extremes, and (with BITREV_PINGPONG_EN) back-to-back frames.
module tb_bitrev_streamer;

  localparam int DATA_W = 16;
  localparam int LOG2N  = 5;
  localparam int N      = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_r;
  logic [DATA_W-1:0] in_i;
  logic              start_sorting;
  logic              out_valid;
  logic [DATA_W-1:0] out_r;
  logic [DATA_W-1:0] out_i;

  int checks = 0;
  int errors = 0;

  logic [2*DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0]   src_r [N];
  logic [DATA_W-1:0]   src_i [N];
  logic [DATA_W-1:0]   obs_r [N];
  logic [DATA_W-1:0]   ramp_tbl [8];

  // Clock and DUT
  always #5 clk = ~clk;

  bitrev_streamer #(.DATA_W(DATA_W), .LOG2N(LOG2N)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_r          (in_r),
    .in_i          (in_i),
    .start_sorting (start_sorting),
    .out_valid     (out_valid),
    .out_r         (out_r),
    .out_i         (out_i)
  );

  function automatic int brev(input int k);
    int r;
    r = 0;
    for (int b = 0; b < LOG2N; b++) if (k[b]) r = r | (1 << (LOG2N - 1 - b));
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_expected(input logic [DATA_W-1:0] ofs);
    for (int j = 0; j < N; j++)
      exp_q.push_back({src_r[brev(j)] + ofs, src_i[brev(j)] + ofs});
  endtask

  // Drive one frame from src_*; gap=1 toggles in_valid every other cycle.
  task automatic fill_frame(input bit gap);
    int k;
    int guard;
    k = 0;
    guard = 0;
    while (k < N && guard < 400) begin
      if (gap && (guard % 2 == 1)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_r = src_r[k];
        in_i = src_i[k];
      end
      if (in_valid && in_ready) k++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    check("fill_accepts", k, N);
  endtask

  // Collect one frame starting right after the last accept; bp drives 0x7FFF.
  task automatic drain_frame(input string tag, input bit bp);
    logic [2*DATA_W-1:0] e;
    tick();
    for (int k = 0; k < N; k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      obs_r[k] = out_r;
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_start"}, start_sorting, (k == 0) ? 1 : 0);
      check({tag, "_r"}, out_r, e[2*DATA_W-1:DATA_W]);
      check({tag, "_i"}, out_i, e[DATA_W-1:0]);
`ifndef BITREV_PINGPONG_EN
      check({tag, "_ready_low"}, in_ready, 0);
`endif
      if (bp) begin
        in_valid = 1'b1;
        in_r = 16'h7FFF;
        in_i = 16'h7FFF;
      end
      tick();
    end
    in_valid = 1'b0;
    check({tag, "_after_valid"}, out_valid, 0);
    check({tag, "_after_ready"}, in_ready, 1);
  endtask

  initial begin
    ramp_tbl = '{16'd0, 16'd16, 16'd8, 16'd24, 16'd4, 16'd20, 16'd12, 16'd28};
    rst = 1'b0;
    in_valid = 1'b0;
    in_r = '0;
    in_i = '0;

    // Reset state
    tick();
    tick();
    check("rst_ready", in_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_start", start_sorting, 0);
    check("rst_r", out_r, 0);
    check("rst_i", out_i, 0);
    rst = 1'b1;
    #1;
    check("ready_after_release", in_ready, 0);
    tick();
    check("ready_next_cycle", in_ready, 1);

    // Ramp frame
    for (int k = 0; k < N; k++) begin
      src_r[k] = 16'(k);
      src_i[k] = 16'(-k);
    end
    load_expected(16'h0);
    fill_frame(1'b0);
    drain_frame("ramp", 1'b0);
    for (int k = 0; k < 8; k++) check("ramp_tbl", obs_r[k], ramp_tbl[k]);
    check("ramp_last", obs_r[N-1], 31);

    // Gapped input, backpressure during drain (single-bank only)
    for (int k = 0; k < N; k++) begin
      src_r[k] = 16'(k * 3 + 1);
      src_i[k] = 16'(~k);
    end
    load_expected(16'h0);
    fill_frame(1'b1);
`ifdef BITREV_PINGPONG_EN
    drain_frame("gap", 1'b0);
`else
    drain_frame("gap", 1'b1);
`endif

    // Next frame must be unaffected by the ignored 0x7FFF writes
    for (int k = 0; k < N; k++) begin
      src_r[k] = 16'(k + 16'h0100);
      src_i[k] = 16'(16'h0200 - k);
    end
    load_expected(16'h0);
    fill_frame(1'b0);
    drain_frame("post_bp", 1'b0);

    // Reset mid-drain at output k=10
    for (int k = 0; k < N; k++) begin
      src_r[k] = 16'(k);
      src_i[k] = 16'(-k);
    end
    fill_frame(1'b0);
    for (int k = 0; k <= 10; k++) tick();
    check("md_k10_r", out_r, brev(10));
    check("md_k10_valid", out_valid, 1);
    rst = 1'b0;
    #1;
    check("md_rst_valid", out_valid, 0);
    check("md_rst_start", start_sorting, 0);
    check("md_rst_r", out_r, 0);
    check("md_rst_i", out_i, 0);
    check("md_rst_ready", in_ready, 0);
    tick();
    tick();
    check("md_hold_valid", out_valid, 0);
    rst = 1'b1;
    #1;
    check("md_release_ready", in_ready, 0);
    tick();
    check("md_ready", in_ready, 1);
    check("md_no_output", out_valid, 0);

    // Extremes after reset
    for (int k = 0; k < N; k++) begin
      src_r[k] = (k % 2 == 0) ? 16'h8000 : 16'h7FFF;
      src_i[k] = (k % 2 == 0) ? 16'h7FFF : 16'h8000;
    end
    load_expected(16'h0);
    fill_frame(1'b0);
    drain_frame("extreme", 1'b0);

`ifdef BITREV_PINGPONG_EN
    // Back-to-back frames: 64 contiguous outputs, starts 32 cycles apart
    for (int k = 0; k < N; k++) begin
      src_r[k] = 16'(k * 5);
      src_i[k] = 16'(k + 16'h0040);
    end
    load_expected(16'h0);
    load_expected(16'h0100);
    for (int t = 0; t < 97; t++) begin
      logic [2*DATA_W-1:0] e;
      if (t < 2 * N) begin
        check("pp_ready", in_ready, 1);
        in_valid = 1'b1;
        in_r = (t < N) ? src_r[t] : src_r[t-N] + 16'h0100;
        in_i = (t < N) ? src_i[t] : src_i[t-N] + 16'h0100;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      check("pp_valid", out_valid, (t >= N && t < 3 * N) ? 1 : 0);
      check("pp_start", start_sorting, (t == N || t == 2 * N) ? 1 : 0);
      if (t >= N && t < 3 * N) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("pp_r", out_r, e[2*DATA_W-1:DATA_W]);
        check("pp_i", out_i, e[DATA_W-1:0]);
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
